// File: rtl/mem_responder.sv
// mem_responder: word-wide memory target with a fixed access latency.
// A request is latched when the FSM is idle, the FSM then stays busy until the
// access completes, and completion raises data_valid for exactly one cycle.
// Requests arriving while busy are dropped; the initiator must retry them.
// Optional feature: define MEM_ALIGN_CHECK_EN to add the err port. Misaligned
// requests (addr[0]=1) then complete without any side effect and flag err.
module mem_responder #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 15,
    parameter int unsigned LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              data_valid
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int unsigned Words = 1 << DEPTH_LOG2;
    // Count runs from LATENCY-2 down to 0 while busy
    localparam int unsigned CntW  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'((LATENCY >= 2) ? LATENCY - 2 : 0);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         count_q, count_d;
    logic                    req_wr_q;
    logic [DEPTH_LOG2-1:0]   req_idx_q;
    logic [DATA_W-1:0]       req_data_q;

    logic                    accept;
    logic                    complete;
    logic                    cmp_wr;
    logic [DEPTH_LOG2-1:0]   cmp_idx;
    logic [DATA_W-1:0]       cmp_data;
    logic                    cmp_mis;
    logic                    mem_we;
    logic                    mem_re;

    logic [DATA_W-1:0]       mem [Words];

    // Only addr[DEPTH_LOG2:1] (and addr[0] with the alignment check) select storage
    logic unused_addr;
    assign unused_addr = ^addr;

`ifdef MEM_ALIGN_CHECK_EN
    logic req_mis_q;
    logic err_q;

    // Misalignment of the request completing this edge (live inputs when idle)
    assign cmp_mis = (state_q == StIdle) ? addr[0] : req_mis_q;
    assign err     = err_q;

    // Alignment flag latched with the request; err pulses alongside data_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            req_mis_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                req_mis_q <= addr[0];
            end
            err_q <= complete & cmp_mis;
        end
    end
`else
    assign cmp_mis = 1'b0;
`endif

    // Next-state logic; when idle the completing request comes straight from the inputs
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        accept   = 1'b0;
        complete = 1'b0;
        busy     = 1'b0;
        cmp_wr   = req_wr_q;
        cmp_idx  = req_idx_q;
        cmp_data = req_data_q;
        unique case (state_q)
            StIdle: begin
                cmp_wr   = wr;
                cmp_idx  = addr[DEPTH_LOG2:1];
                cmp_data = data_in;
                if (enable) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        complete = 1'b1;
                    end else begin
                        state_d = StBusy;
                        count_d = CntLoad;
                    end
                end
            end
            StBusy: begin
                busy = 1'b1;
                if (count_q == '0) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end else begin
                    count_d = count_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset aborts an in-flight access, so gate both array and output updates with it
    assign mem_we = complete & cmp_wr & ~cmp_mis & ~rst;
    assign mem_re = complete & ~cmp_wr & ~cmp_mis;

    // FSM, request latch, read data and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            req_wr_q   <= 1'b0;
            req_idx_q  <= '0;
            req_data_q <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            data_valid <= complete;
            if (accept) begin
                req_wr_q   <= wr;
                req_idx_q  <= addr[DEPTH_LOG2:1];
                req_data_q <= data_in;
            end
            if (mem_re) begin
                data_out <= mem[cmp_idx];
            end
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cmp_idx] <= cmp_data;
        end
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-wide memory responder on the target side of the CPU's memory request interface (enable / wr / addr / data_in -> data_out).
- Models a multi-cycle memory with a fixed access latency, a busy indication and a one-cycle completion pulse.
- Used as the backing store for instruction and data memory once fetch and load/store become multi-cycle.
- Internal storage is a word array indexed by the byte address with bit 0 dropped.

Parameters:
- ADDR_W, 16, request address width in bits (byte address).
- DATA_W, 16, data word width.
- DEPTH_LOG2, 15, log2 of the number of stored words; legal range 1..ADDR_W-1.
- LATENCY, 4, cycles from request acceptance to completion; must be >= 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  request strobe, sampled on each rising edge.
- wr  in  1  1 = write, 0 = read; sampled with enable.
- addr  in  ADDR_W  byte address; word index = addr[DEPTH_LOG2:1].
- data_in  in  DATA_W  write data; sampled with enable.
- data_out  out  DATA_W  read data; registered.
- busy  out  1  a request is in flight; new requests are ignored.
- data_valid  out  1  one-cycle completion pulse, for reads and writes.
- err  out  1  misaligned-request flag; present only with MEM_ALIGN_CHECK_EN.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, count=0, busy=0, data_valid=0, data_out=0, err=0.
  - Array contents are not cleared.
  - An in-flight request is aborted: no write commit and no data_valid.
- FSM states are IDLE and BUSY.
- IDLE:
  - If enable=1 at an edge, latch wr, addr and data_in.
  - If LATENCY=1, complete at that same edge (see Completion).
  - Otherwise go to BUSY with count=LATENCY-2.
- BUSY:
  - busy=1.
  - When count>0, decrement it.
  - When count=0, complete at that edge and return to IDLE.
- Completion edge:
  - Write: array[idx] <= latched data; data_out is unchanged.
  - Read: data_out <= array[idx].
  - data_valid=1 for exactly the next cycle, with busy=0 in that same cycle.
- Timing:
  - A request presented in cycle N yields data_valid in cycle N+LATENCY.
  - busy is high in cycles N+1 .. N+LATENCY-1.
- Back-to-back:
  - A request may be presented in the data_valid cycle (state is IDLE) and is accepted.
  - Maximum throughput is one request per LATENCY cycles.
- enable=1 while busy=1 is ignored: no queueing and no side effects. The initiator must hold or reissue the request.
- Input changes during BUSY do not affect the in-flight request, because all inputs are latched at acceptance.
- Index arithmetic:
  - idx = latched addr[DEPTH_LOG2:1].
  - Upper address bits are ignored, so addresses alias modulo 2^(DEPTH_LOG2+1) bytes.
- data_out holds its last read value indefinitely.
- A read issued after a write to the same word returns the new value, because the write commits before the read is accepted.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- With the macro:
  - The err port exists.
  - A request with addr[0]=1 is still accepted and still takes LATENCY cycles.
  - At completion, no array write occurs and data_out is unchanged.
  - err=1 together with data_valid=1 for that one cycle; err=0 otherwise.
- Without the macro:
  - There is no err port.
  - addr[0] is ignored, so misaligned requests access word addr[DEPTH_LOG2:1] normally.

Test Plan:
- Reset mid-flight: with LATENCY=4, write 0xBEEF to 0x0010, assert rst in cycle N+2; then read 0x0010 -> returns the prior contents (bench pre-loaded 0x1234 before the aborted write), busy=0 and data_valid=0 immediately after reset.
- Latency and handshake: with LATENCY=4, write 0xBEEF to 0x0010 in cycle N -> busy=1 in N+1..N+3, data_valid=1 only in N+4, data_out unchanged. Then read 0x0010 -> data_out=0xBEEF with data_valid four cycles later.
- Request dropped while busy: read 0x0020 issued in N, enable pulses in N+1 and N+2 with wr=1 to 0x0030 -> exactly one data_valid (in N+4); a later read of 0x0030 returns its pre-test value.
- Back-to-back: issue a new read in the data_valid cycle -> accepted, second data_valid 4 cycles later. With LATENCY=1, consecutive reads give data_valid every cycle.
- Aliasing: DEPTH_LOG2=4, write 0x00AA to 0x0002, read 0x0022 -> 0x00AA.
- Alignment (with MEM_ALIGN_CHECK_EN): write 0x5555 to 0x0011 -> data_valid=1 and err=1 in N+4; read 0x0010 returns the old value. Without the macro, the same write lands at word 8 and err is absent.
